// File: rtl/uart_cmd_master_if.sv
// Command/response handshake bundle for uart_cmd_master.
// The master modport belongs to the host logic that issues commands.
// The slave modport belongs to the UART bridge that serves them.
interface uart_cmd_master_if;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        tx_busy;
  logic        cmd_cmplt;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy;
  logic        resp_timeout;

  modport master (
    output cmd, snd_cmd, clr_resp_rdy,
    input  tx_busy, cmd_cmplt, resp, resp_rdy, resp_timeout
  );

  modport slave (
    input  cmd, snd_cmd, clr_resp_rdy,
    output tx_busy, cmd_cmplt, resp, resp_rdy, resp_timeout
  );
endinterface

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: host end of the command/response UART link.
// The transmit path sends a 16-bit command as two 8N1 frames, high byte first.
// The receive path collects single-byte responses.
// Optional macro RESP_TIMEOUT_EN adds a response timeout counter.
// Without that macro, resp_timeout is tied low.
module uart_cmd_master #(
  parameter int BAUD_DIV       = 108,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  uart_cmd_master_if.slave  bus,
  input  logic              RX,
  output logic              TX
);

  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);

  typedef enum logic [1:0] {TX_IDLE, TX_SEND_HI, TX_SEND_LO} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- transmit path ----------------
  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  // Both frames, low-byte frame in the upper half. This register also serves
  // as the command hold register.
  logic [19:0]   tx_frame;
  logic          tx_tc, tx_byte_done, tx_start, tx_done;
  logic          tx_busy_q, cmd_cmplt_q;

  assign tx_tc        = (tx_cnt == BAUD_LAST);
  assign tx_byte_done = tx_tc && (tx_bit == 4'd9);
  assign TX           = tx_frame[0];

  // TX state register
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  // TX next-state logic: accept a command in idle, then step through the two frames
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    tx_next  = tx_state;
    tx_start = 1'b0;
    tx_done  = 1'b0;
    unique case (tx_state)
      TX_IDLE: if (bus.snd_cmd) begin
        tx_next  = TX_SEND_HI;
        tx_start = 1'b1;
      end
      TX_SEND_HI: if (tx_byte_done) tx_next = TX_SEND_LO;
      TX_SEND_LO: if (tx_byte_done) begin
        tx_next = TX_IDLE;
        tx_done = 1'b1;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // TX datapath: load both frames, then shift right once per bit period, filling with idle 1s
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_frame    <= '1;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_busy_q   <= 1'b0;
      cmd_cmplt_q <= 1'b0;
    end else if (tx_start) begin
      tx_frame    <= {1'b1, bus.cmd[7:0], 1'b0, 1'b1, bus.cmd[15:8], 1'b0};
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_busy_q   <= 1'b1;
      cmd_cmplt_q <= 1'b0;
    end else if (tx_state != TX_IDLE) begin
      tx_cnt <= tx_tc ? '0 : tx_cnt + 1'b1;
      if (tx_tc) begin
        tx_frame <= {1'b1, tx_frame[19:1]};
        tx_bit   <= tx_byte_done ? 4'd0 : tx_bit + 1'b1;
      end
      if (tx_done) begin
        tx_busy_q   <= 1'b0;
        cmd_cmplt_q <= 1'b1;
      end
    end
  end

  assign bus.tx_busy   = tx_busy_q;
  assign bus.cmd_cmplt = cmd_cmplt_q;

  // ---------------- receive path ----------------
  rx_state_t     rx_state, rx_next;
  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_fall, rx_half, rx_tc, rx_good;
  logic [7:0]    resp_q;
  logic          resp_rdy_q;

  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_half = (rx_cnt == BAUD_HALF);
  assign rx_tc   = (rx_cnt == BAUD_LAST);

  // RX synchronizer and edge-detect stage, preset to the idle-high line level
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  // RX next-state logic: mid-bit sampling, glitch rejection, stop-bit validation
  always_comb begin
    rx_next = rx_state;
    rx_good = 1'b0;
    unique case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tc && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tc) begin
        rx_next = RX_IDLE;
        rx_good = rx_s2;
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  // RX bit timing: half a bit to the start midpoint, then whole bits
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt <= '0;
      rx_bit <= '0;
    end else begin
      unique case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
        end
        RX_START: rx_cnt <= rx_half ? '0 : rx_cnt + 1'b1;
        default: begin
          rx_cnt <= rx_tc ? '0 : rx_cnt + 1'b1;
          if (rx_state == RX_DATA && rx_tc) rx_bit <= rx_bit + 1'b1;
        end
      endcase
    end
  end

  // RX data shifter, LSB first
  // NOTE: a pure data register needs no reset; it is fully refilled before it is ever used.
  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_tc) rx_shift <= {rx_s2, rx_shift[7:1]};
  end

  // Response register and ready flag; a completing frame wins over a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q     <= 8'h00;
      resp_rdy_q <= 1'b0;
    end else if (rx_good) begin
      resp_q     <= rx_shift;
      resp_rdy_q <= 1'b1;
    end else if (bus.clr_resp_rdy || tx_start) begin
      resp_rdy_q <= 1'b0;
    end
  end

  assign bus.resp     = resp_q;
  assign bus.resp_rdy = resp_rdy_q;

  // ---------------- optional response timeout ----------------
`ifdef RESP_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        to_armed, resp_timeout_q;

  // Timeout counter: armed when a command completes, disarmed by a good frame
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt         <= '0;
      to_armed       <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else if (tx_start) begin
      to_armed       <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else if (tx_done) begin
      to_cnt   <= '0;
      to_armed <= 1'b1;
    end else if (rx_good) begin
      to_armed <= 1'b0;
    end else if (to_armed && !resp_rdy_q) begin
      to_cnt <= to_cnt + 32'd1;
      if (to_cnt + 32'd1 == 32'(TIMEOUT_CYCLES)) begin
        resp_timeout_q <= 1'b1;
        to_armed       <= 1'b0;
      end
    end
  end

  assign bus.resp_timeout = resp_timeout_q;
`else
  assign bus.resp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_master.sv
// Testbench for uart_cmd_master with BAUD_DIV=16 and TIMEOUT_CYCLES=1000.
// Expected TX waveforms and received bytes come from a frame-level model.
module tb_uart_cmd_master;
  localparam int BD = 16;
  localparam int TO = 1000;

  logic clk = 1'b0;
  logic rst;
  logic rx_drv;
  logic rx_line, tx_line;
  bit   loop_en;
  bit   mon_en;
  int   n_checks = 0;
  int   n_err    = 0;
  logic [7:0] got_q[$];

  uart_cmd_master_if bus ();

  uart_cmd_master #(.BAUD_DIV(BD), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .RX  (rx_line),
    .TX  (tx_line)
  );

  assign rx_line = loop_en ? tx_line : rx_drv;

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Level TX must show k cycles after a command is accepted.
  function automatic logic exp_tx(input logic [15:0] c, input int k);
    logic [7:0] b;
    int pos;
    b   = (k < 10 * BD) ? c[15:8] : c[7:0];
    pos = (k % (10 * BD)) / BD;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  // Advance one clock; sample at the falling edge. With the monitor on,
  // each response is captured and then cleared.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (mon_en) begin
      if (bus.clr_resp_rdy) begin
        check("clr_rdy", bus.resp_rdy, 1'b0);
        bus.clr_resp_rdy = 1'b0;
      end else if (bus.resp_rdy) begin
        got_q.push_back(bus.resp);
        bus.clr_resp_rdy = 1'b1;
      end
    end
  endtask

  task automatic send_and_check(input logic [15:0] c, input bit loop, input bit intrude);
    int bad;
    bad     = 0;
    loop_en = loop;
    mon_en  = loop;
    got_q.delete();
    check("tx_idle", tx_line, 1'b1);
    bus.cmd     = c;
    bus.snd_cmd = 1'b1;
    step();
    bus.snd_cmd = 1'b0;
    bus.cmd     = 16'($urandom);
    check("to_clr", bus.resp_timeout, 1'b0);
    for (int k = 0; k < 20 * BD; k++) begin
      if (k > 0) step();
      if (tx_line !== exp_tx(c, k) || bus.tx_busy !== 1'b1 || bus.cmd_cmplt !== 1'b0) bad++;
      if (intrude && k == 10 * BD) begin
        bus.cmd     = 16'h1234;
        bus.snd_cmd = 1'b1;
      end
      if (intrude && k == 10 * BD + 1) bus.snd_cmd = 1'b0;
    end
    check("tx_wave", bad, 0);
    step();
    check("cmplt", bus.cmd_cmplt, 1'b1);
    check("busy_off", bus.tx_busy, 1'b0);
    check("tx_end", tx_line, 1'b1);
    if (loop) begin
      repeat (20) step();
      check("rx_count", got_q.size(), 2);
      if (got_q.size() >= 2) begin
        check("rx_hi", got_q[0], c[15:8]);
        check("rx_lo", got_q[1], c[7:0]);
      end
    end
    mon_en           = 1'b0;
    loop_en          = 1'b0;
    bus.clr_resp_rdy = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (BD) step();
    end
    rx_drv = 1'b1;
    repeat (4) step();
  endtask

  task automatic clear_rdy();
    bus.clr_resp_rdy = 1'b1;
    step();
    bus.clr_resp_rdy = 1'b0;
    check("clr_direct", bus.resp_rdy, 1'b0);
  endtask

  initial begin
    logic [7:0]  b1, b2, b3;
    logic [15:0] c;
    rst              = 1'b1;
    rx_drv           = 1'b1;
    loop_en          = 1'b0;
    mon_en           = 1'b0;
    bus.cmd          = 16'h0000;
    bus.snd_cmd      = 1'b0;
    bus.clr_resp_rdy = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // reset state
    check("rst_tx", tx_line, 1'b1);
    check("rst_busy", bus.tx_busy, 1'b0);
    check("rst_cmplt", bus.cmd_cmplt, 1'b0);
    check("rst_resp", bus.resp, 8'h00);
    check("rst_rdy", bus.resp_rdy, 1'b0);
    check("rst_to", bus.resp_timeout, 1'b0);

    // fixed and random command transmissions, some looped back to RX
    send_and_check(16'hA55A, 1'b0, 1'b0);
    send_and_check(16'h3C0F, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) send_and_check(16'($urandom), 1'b1, 1'b0);

    // snd_cmd during a send is ignored
    send_and_check(16'hABCD, 1'b0, 1'b1);

    // direct RX frames: good, framing error, glitch, overwrite, random
    clear_rdy();
    b1 = 8'($urandom_range(1, 255));
    rx_send(b1, 1'b1);
    check("rx_good", bus.resp, b1);
    check("rx_good_rdy", bus.resp_rdy, 1'b1);
    clear_rdy();
    rx_send(8'h81, 1'b0);
    check("ferr_rdy", bus.resp_rdy, 1'b0);
    check("ferr_resp", bus.resp, b1);
    rx_drv = 1'b0;
    step();
    rx_drv = 1'b1;
    repeat (12 * BD) step();
    check("glitch_rdy", bus.resp_rdy, 1'b0);
    check("glitch_resp", bus.resp, b1);
    b2 = 8'($urandom);
    b3 = 8'($urandom);
    rx_send(b2, 1'b1);
    rx_send(b3, 1'b1);
    check("ovw_resp", bus.resp, b3);
    check("ovw_rdy", bus.resp_rdy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      b1 = 8'($urandom);
      clear_rdy();
      rx_send(b1, 1'b1);
      check("rx_rand", bus.resp, b1);
    end

    // reset in the middle of the high byte
    bus.cmd     = 16'($urandom);
    bus.snd_cmd = 1'b1;
    step();
    bus.snd_cmd = 1'b0;
    repeat (50) step();
    rst = 1'b1;
    step();
    check("mid_rst_tx", tx_line, 1'b1);
    check("mid_rst_busy", bus.tx_busy, 1'b0);
    check("mid_rst_cmplt", bus.cmd_cmplt, 1'b0);
    check("mid_rst_resp", bus.resp, 8'h00);
    rst = 1'b0;
    step();
    send_and_check(16'($urandom), 1'b0, 1'b0);

    // response timeout after a completed command with a silent RX line
    for (int j = 1; j <= TO; j++) begin
      step();
      if (j == TO - 1) check("to_early", bus.resp_timeout, 1'b0);
    end
`ifdef RESP_TIMEOUT_EN
    check("to_fire", bus.resp_timeout, 1'b1);
`else
    check("to_tied", bus.resp_timeout, 1'b0);
`endif
    c = 16'($urandom);
    send_and_check(c, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
